// File: rtl/connect4_pkg.sv
// Shared types and constants for the 4x4 connect-four turn controller.
package connect4_pkg;

    localparam int BOARD_W = 16;

    // One-hot-low column select codes.
    localparam logic [3:0] COL0 = 4'b1110;
    localparam logic [3:0] COL1 = 4'b1101;
    localparam logic [3:0] COL2 = 4'b1011;
    localparam logic [3:0] COL3 = 4'b0111;

    localparam logic [4:0] POS_NONE = 5'b11111;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_MOVE,
        PLACE,
        CHECK,
        GAME_OVER
    } state_t;

    typedef struct packed {
        logic       ok;
        logic [1:0] idx;
    } col_sel_t;

    // Map a column code to an index; anything other than exactly one low bit is rejected.
    function automatic col_sel_t col_decode(input logic [3:0] code);
        col_sel_t s;
        s.ok  = 1'b1;
        s.idx = 2'd0;
        case (code)
            COL0:    s.idx = 2'd0;
            COL1:    s.idx = 2'd1;
            COL2:    s.idx = 2'd2;
            COL3:    s.idx = 2'd3;
            default: s.ok  = 1'b0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/win_checker.sv
// Combinational four-in-a-row detector for one player's 4x4 occupancy bitmap.
module win_checker
    import connect4_pkg::*;
(
    input  logic [BOARD_W-1:0] i_board,
    output logic               o_win
);

    // Four rows, four columns, and the two diagonals (cells 0/5/10/15 and 3/6/9/12).
    localparam logic [9:0][BOARD_W-1:0] LINE_MASK = {
        16'h000F, 16'h00F0, 16'h0F00, 16'hF000,
        16'h1111, 16'h2222, 16'h4444, 16'h8888,
        16'h8421, 16'h1248
    };

    // Flag a win when every cell of any line is occupied.
    always_comb begin
        o_win = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if ((i_board & LINE_MASK[i]) == LINE_MASK[i]) begin
                o_win = 1'b1;
            end
        end
    end

endmodule

// File: rtl/turn_controller.sv
// Two-player 4x4 connect-four turn sequencer: move arbitration, disc placement,
// win/draw detection and optional per-turn timeout.
module turn_controller
    import connect4_pkg::*;
#(
    parameter int TIMEOUT = 0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               new_game,
    input  logic [3:0]         p1_col,
    input  logic [3:0]         p2_col,
    input  logic               p1_valid,
    input  logic               p2_valid,
    output logic [4:0]         drop_pos,
    output logic               drop_valid,
    output logic               current_player,
    output logic [BOARD_W-1:0] board_p1,
    output logic [BOARD_W-1:0] board_p2,
    output logic [3:0]         col_full,
    output logic [1:0]         winner,
    output logic               game_over,
    output logic               move_err,
    output logic               timeout
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TC_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    state_t             r_state;
    logic [BOARD_W-1:0] r_board_p1;
    logic [BOARD_W-1:0] r_board_p2;
    logic [3:0][2:0]    r_height;
    logic               r_cur_player;
    logic [1:0]         r_winner;
    logic [4:0]         r_drop_pos;
    logic               r_drop_valid;
    logic               r_move_err;
    logic               r_timeout;
    logic [1:0]         r_sel_col;
    logic [CW-1:0]      r_tcnt;

    logic               w_req_valid;
    logic [3:0]         w_req_code;
    col_sel_t           w_req_sel;
    logic               w_accept;
    logic               w_tc_hit;
    logic [3:0]         w_cell;
    logic [BOARD_W-1:0] w_cur_board;
    logic               w_win;

    // Only the player whose turn it is can issue a request.
    assign w_req_valid = r_cur_player ? p2_valid : p1_valid;
    assign w_req_code  = r_cur_player ? p2_col   : p1_col;
    assign w_req_sel   = col_decode(w_req_code);
    assign w_accept    = (r_state == WAIT_MOVE) && w_req_valid && w_req_sel.ok
                         && !col_full[w_req_sel.idx];
    assign w_tc_hit    = (TIMEOUT > 0) && (r_tcnt == TC_LAST);

    // Landing cell is height*4 + col; height is below 4 for any accepted column.
    assign w_cell      = {r_height[r_sel_col][1:0], r_sel_col};
    assign w_cur_board = r_cur_player ? r_board_p2 : r_board_p1;

    win_checker u_win_checker (
        .i_board (w_cur_board),
        .o_win   (w_win)
    );

    // A column is full once its height reaches four discs.
    always_comb begin
        col_full = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            col_full[c] = (r_height[c] == 3'd4);
        end
    end

    // Game FSM with registered outputs; new_game overrides everything else.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_board_p1   <= '0;
            r_board_p2   <= '0;
            r_height     <= '0;
            r_cur_player <= 1'b0;
            r_winner     <= WIN_NONE;
            r_drop_pos   <= POS_NONE;
            r_drop_valid <= 1'b0;
            r_move_err   <= 1'b0;
            r_timeout    <= 1'b0;
            r_sel_col    <= 2'd0;
            r_tcnt       <= '0;
        end else begin
            r_drop_valid <= 1'b0;
            r_drop_pos   <= POS_NONE;
            r_move_err   <= 1'b0;
            r_timeout    <= 1'b0;
            if (new_game) begin
                r_state      <= WAIT_MOVE;
                r_board_p1   <= '0;
                r_board_p2   <= '0;
                r_height     <= '0;
                r_cur_player <= 1'b0;
                r_winner     <= WIN_NONE;
                r_tcnt       <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_tcnt <= '0;
                    end
                    WAIT_MOVE: begin
                        if (w_accept) begin
                            r_sel_col <= w_req_sel.idx;
                            r_tcnt    <= '0;
                            r_state   <= PLACE;
                        end else begin
                            if (w_req_valid) begin
                                r_move_err <= 1'b1;
                            end
                            if (w_tc_hit) begin
                                r_timeout    <= 1'b1;
                                r_cur_player <= ~r_cur_player;
                                r_tcnt       <= '0;
                            end else if (TIMEOUT > 0) begin
                                r_tcnt <= r_tcnt + CW'(1);
                            end
                        end
                    end
                    PLACE: begin
                        if (r_cur_player) begin
                            r_board_p2[w_cell] <= 1'b1;
                        end else begin
                            r_board_p1[w_cell] <= 1'b1;
                        end
                        if (r_height[r_sel_col] < 3'd4) begin
                            r_height[r_sel_col] <= r_height[r_sel_col] + 3'd1;
                        end
                        r_drop_pos   <= {1'b0, w_cell};
                        r_drop_valid <= 1'b1;
                        r_state      <= CHECK;
                    end
                    CHECK: begin
                        if (w_win) begin
                            r_winner <= r_cur_player ? WIN_P2 : WIN_P1;
                            r_state  <= GAME_OVER;
                        end else if (&col_full) begin
                            r_winner <= WIN_DRAW;
                            r_state  <= GAME_OVER;
                        end else begin
                            r_cur_player <= ~r_cur_player;
                            r_state      <= WAIT_MOVE;
                        end
                        r_tcnt <= '0;
                    end
                    GAME_OVER: begin
                        r_tcnt <= '0;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign drop_pos       = r_drop_pos;
    assign drop_valid     = r_drop_valid;
    assign current_player = r_cur_player;
    assign board_p1       = r_board_p1;
    assign board_p2       = r_board_p2;
    assign winner         = r_winner;
    assign game_over      = (r_state == GAME_OVER);
    assign move_err       = r_move_err;
    assign timeout        = r_timeout;

endmodule

// File: tb/tb_turn_controller.sv
// Scoreboard bench for turn_controller with a per-turn timeout of 16 cycles.
module tb_turn_controller;

    localparam logic [3:0] C0 = 4'b1110;
    localparam logic [3:0] C1 = 4'b1101;
    localparam logic [3:0] C2 = 4'b1011;
    localparam logic [3:0] C3 = 4'b0111;

    logic        clk;
    logic        reset_n;
    logic        new_game;
    logic [3:0]  p1_col;
    logic [3:0]  p2_col;
    logic        p1_valid;
    logic        p2_valid;
    logic [4:0]  drop_pos;
    logic        drop_valid;
    logic        current_player;
    logic [15:0] board_p1;
    logic [15:0] board_p2;
    logic [3:0]  col_full;
    logic [1:0]  winner;
    logic        game_over;
    logic        move_err;
    logic        timeout;

    turn_controller #(.TIMEOUT(16)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .new_game       (new_game),
        .p1_col         (p1_col),
        .p2_col         (p2_col),
        .p1_valid       (p1_valid),
        .p2_valid       (p2_valid),
        .drop_pos       (drop_pos),
        .drop_valid     (drop_valid),
        .current_player (current_player),
        .board_p1       (board_p1),
        .board_p2       (board_p2),
        .col_full       (col_full),
        .winner         (winner),
        .game_over      (game_over),
        .move_err       (move_err),
        .timeout        (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int idle_bad = 0;
    logic [4:0] exp_q[$];

    // Reference game state.
    int          m_h[4];
    logic [15:0] m_b1, m_b2;
    bit          m_cur, m_over, m_active;
    logic [1:0]  m_win;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int col_of(input logic [3:0] code);
        case (code)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic bit line4(input logic [15:0] b);
        bit found;
        found = 1'b0;
        for (int r = 0; r < 4; r++)
            if (b[r*4] && b[r*4+1] && b[r*4+2] && b[r*4+3]) found = 1'b1;
        for (int c = 0; c < 4; c++)
            if (b[c] && b[c+4] && b[c+8] && b[c+12]) found = 1'b1;
        if (b[0] && b[5] && b[10] && b[15]) found = 1'b1;
        if (b[3] && b[6] && b[9] && b[12]) found = 1'b1;
        return found;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_h[i] = 0;
        m_b1 = '0; m_b2 = '0; m_cur = 1'b0; m_over = 1'b0; m_win = 2'b00;
    endtask

    // Drop checker: each drop_valid pulse must match the oldest expected position.
    always @(negedge clk) begin
        if (!drop_valid && drop_pos != 5'h1F) idle_bad++;
        if (drop_valid) begin
            if (exp_q.size() == 0) chk("unexpected_drop", {27'd0, drop_pos}, 32'h1F);
            else chk("drop_pos", {27'd0, drop_pos}, {27'd0, exp_q.pop_front()});
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_drop_pos"}, drop_pos, 5'h1F);
        chk({tag, "_drop_valid"}, drop_valid, 0);
        chk({tag, "_player"}, current_player, 0);
        chk({tag, "_board_p1"}, board_p1, 0);
        chk({tag, "_board_p2"}, board_p2, 0);
        chk({tag, "_col_full"}, col_full, 0);
        chk({tag, "_winner"}, winner, 0);
        chk({tag, "_game_over"}, game_over, 0);
        chk({tag, "_move_err"}, move_err, 0);
        chk({tag, "_timeout"}, timeout, 0);
    endtask

    task automatic ngame(input bit with_move);
        new_game = 1'b1; p1_valid = with_move; p1_col = C0;
        step();
        new_game = 1'b0; p1_valid = 1'b0; p1_col = 4'hF;
        model_clear();
        m_active = 1'b1;
        chk("ng_player", current_player, 0);
        chk("ng_board_p1", board_p1, 0);
        chk("ng_winner", winner, 0);
        chk("ng_game_over", game_over, 0);
    endtask

    // Drive one request cycle; the model decides acceptance and pushes the expected drop.
    task automatic req(input bit v1, input logic [3:0] c1, input bit v2, input logic [3:0] c2);
        bit v, acc, err;
        int c;
        v   = m_cur ? v2 : v1;
        c   = col_of(m_cur ? c2 : c1);
        acc = m_active && !m_over && v && (c >= 0) && (c < 4 ? m_h[c & 3] < 4 : 1'b0);
        err = m_active && !m_over && v && !acc;
        if (acc) exp_q.push_back(5'(m_h[c] * 4 + c));
        p1_valid = v1; p1_col = c1; p2_valid = v2; p2_col = c2;
        step();
        p1_valid = 1'b0; p2_valid = 1'b0; p1_col = 4'hF; p2_col = 4'hF;
        chk("move_err", move_err, err);
        chk("timeout", timeout, 0);
        if (acc) begin
            step();
            chk("drop_valid", drop_valid, 1);
            if (m_cur) m_b2[m_h[c] * 4 + c] = 1'b1;
            else       m_b1[m_h[c] * 4 + c] = 1'b1;
            m_h[c]++;
            step();
            chk("drop_valid_end", drop_valid, 0);
            if (line4(m_cur ? m_b2 : m_b1)) begin
                m_win  = m_cur ? 2'b10 : 2'b01;
                m_over = 1'b1;
            end else if (m_h[0] == 4 && m_h[1] == 4 && m_h[2] == 4 && m_h[3] == 4) begin
                m_win  = 2'b11;
                m_over = 1'b1;
            end else begin
                m_cur = !m_cur;
            end
        end
        chk("player", current_player, m_cur);
        chk("board_p1", board_p1, m_b1);
        chk("board_p2", board_p2, m_b2);
        chk("winner", winner, m_win);
        chk("game_over", game_over, m_over);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b1; new_game = 1'b0;
        p1_valid = 1'b0; p2_valid = 1'b0; p1_col = 4'hF; p2_col = 4'hF;
        model_clear();
        m_active = 1'b0;
        #1 reset_n = 1'b0;
        #2;
        check_reset_outputs("rst");
        step(); step();
        reset_n = 1'b1;
        req(1, C0, 0, C0);

        // First drop lands at cell 0, turn passes to P2.
        ngame(0);
        req(1, C0, 0, C0);
        chk("first_board_p1", board_p1, 16'h0001);
        chk("first_player", current_player, 1);

        // Stack col0 to the top, then over-fill and illegal codes.
        req(0, C0, 1, C0);
        req(1, C0, 0, C0);
        req(0, C0, 1, C0);
        chk("col0_full", col_full, 4'b0001);
        req(1, C0, 0, C0);
        req(1, 4'b1100, 0, C0);
        req(1, 4'b1111, 0, C0);

        // Simultaneous and out-of-turn requests.
        ngame(0);
        req(1, C1, 1, C2);
        req(1, C3, 0, C0);
        req(0, C0, 1, C2);
        req(0, C0, 1, C3);

        // Vertical win for P1 in col2, then requests are ignored.
        ngame(0);
        for (int i = 0; i < 3; i++) begin
            req(1, C2, 0, C0);
            req(0, C0, 1, C0);
        end
        req(1, C2, 0, C0);
        chk("win_winner", winner, 2'b01);
        chk("win_board_p1", board_p1, 16'h4444);
        req(1, C1, 1, C1);
        req(1, C3, 0, C0);

        // Timeout after 16 idle cycles, then a move on the timeout cycle wins.
        ngame(0);
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i >= 15) chk("timeout_idle", timeout, (i == 16) ? 1 : 0);
        end
        m_cur = 1'b1;
        chk("timeout_player", current_player, 1);
        step();
        chk("timeout_pulse_end", timeout, 0);
        for (int i = 0; i < 14; i++) step();
        req(0, C0, 1, C0);

        // new_game beats a same-cycle move, then a full board with no line.
        ngame(1);
        for (int k = 0; k < 2; k++) begin
            req(1, C0, 0, C0); req(0, C0, 1, C2);
            req(1, C1, 0, C0); req(0, C0, 1, C3);
            req(1, C2, 0, C0); req(0, C0, 1, C0);
            req(1, C3, 0, C0); req(0, C0, 1, C1);
        end
        chk("draw_winner", winner, 2'b11);
        chk("draw_col_full", col_full, 4'hF);

        // Asynchronous reset while the FSM sits in CHECK.
        ngame(0);
        p1_valid = 1'b1; p1_col = C1;
        step();
        p1_valid = 1'b0; p1_col = 4'hF;
        step();
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_clear();
        m_active = 1'b0;
        step();
        reset_n = 1'b1;
        req(1, C0, 0, C0);
        step();

        chk("drop_pos_idle", idle_bad, 0);
        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/turn_controller.md
TURN_CONTROLLER -- requirements
Module: turn_controller

Interface
REQ-001 Parameter: TIMEOUT, default 0, cycles allowed per turn before the turn passes; 0 disables the timeout.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 new_game  input  1  synchronous start/clear request.
REQ-005 p1_col / p2_col  input  4 each  player column select, one-hot-low: 1110=col0, 1101=col1, 1011=col2, 0111=col3.
REQ-006 p1_valid / p2_valid  input  1 each  move request strobe per player.
REQ-007 drop_pos  output  5  placed cell = row*4+col, row 0 bottom; 5'b11111 when no placement.
REQ-008 drop_valid  output  1  one-cycle pulse with drop_pos.
REQ-009 current_player  output  1  0=P1, 1=P2.
REQ-010 board_p1 / board_p2  output  16 each  occupancy bitmaps, bit index = cell position.
REQ-011 col_full  output  4  bit c set when column c holds 4 discs.
REQ-012 winner  output  2  00 none, 01 P1, 10 P2, 11 draw.
REQ-013 game_over, move_err, timeout  output  1 each  level; pulse; pulse.

Function
REQ-014 FSM states SHALL be IDLE, WAIT_MOVE, PLACE, CHECK, GAME_OVER.
REQ-015 IDLE: new_game -> WAIT_MOVE with boards, column heights, winner cleared and current_player=P1.
REQ-016 new_game SHALL apply as REQ-015 from any state and take priority over a same-cycle move.
REQ-017 WAIT_MOVE: only the current player's valid is considered; the other player's valid is ignored, including when both arrive together.
REQ-018 An accepted request SHALL have exactly one column bit low and the target column not full; otherwise pulse move_err one cycle, stay in WAIT_MOVE, no board change.
REQ-019 Acceptance edge N -> PLACE; at edge N+1: set board bit (height*4+col), increment that column height (3 bits, saturate at 4), drive drop_pos, pulse drop_valid.
REQ-020 CHECK (edge N+2): evaluate the current player's bitmap for 4 in a row (4 rows, 4 columns, 2 diagonals).
REQ-021 Win -> GAME_OVER with winner=player code; else all columns full -> GAME_OVER with winner=11; else toggle current_player, go to WAIT_MOVE.
REQ-022 GAME_OVER: game_over=1, all valids ignored, hold until new_game.
REQ-023 drop_pos SHALL be 5'b11111 in every cycle in which drop_valid=0.
REQ-024 Timeout (TIMEOUT>0): cycle counter runs in WAIT_MOVE and clears on acceptance or player change; at count TIMEOUT-1 pulse timeout, toggle current_player, stay in WAIT_MOVE.
REQ-025 Timeout and a same-cycle accepted move: the move wins, no timeout pulse.

Reset
REQ-026 reset_n=0 SHALL immediately force: state IDLE, boards 0, heights 0, current_player 0, winner 00, game_over 0, drop_valid 0, drop_pos 11111, move_err 0, timeout 0, col_full 0000, timeout counter 0.
REQ-027 Reset mid-game SHALL discard the game; play resumes only after new_game.

Structure
REQ-028 Package connect4_pkg SHALL hold: FSM state enum, column codes COL0..COL3, POS_NONE=5'b11111, winner codes, board width 16.
REQ-029 Sub-module win_checker (combinational, 16-bit bitmap in, win flag out) SHALL hold the 10 line masks.

Verification
REQ-030 Reset, new_game, p1_valid with p1_col=1110 -> drop_pos=0 with drop_valid one cycle later; board_p1=0x0001; current_player=1.
REQ-031 Alternating drops into col0 -> drop_pos 0,4,8,12, col_full=0001; fifth col0 request -> move_err, no drop_valid.
REQ-032 P1 col2, P2 col0 repeated, P1's fourth col2 -> winner=01, game_over=1, board_p1=0x4444; subsequent valids ignored.
REQ-033 p1_valid and p2_valid together on P1's turn -> only P1 placed; p2_valid alone on P1's turn -> no change.
REQ-034 TIMEOUT=16, no input for 16 cycles in WAIT_MOVE -> timeout pulse, current_player=1; new_game, fill board without a line -> winner=11.
REQ-035 reset_n low mid-CHECK -> all outputs at reset values before the next clk edge.
